// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per clock, registered carry.
// Define ADD_SUB_EN to add a 'sub' port that computes a - b (a + ~b + 1).
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int SAFE_CHUNK = (CHUNK > 0) ? CHUNK : 1;
    localparam int N          = WIDTH / SAFE_CHUNK;
    localparam int IW         = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || WIDTH < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_bad_cfg
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] s;
    logic             c;

    // The only adder in the block: one CHUNK-bit slice plus the carry register.
    assign ca = a_q[idx*CHUNK +: CHUNK];
    assign cb = b_q[idx*CHUNK +: CHUNK];
    assign {c, s} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
`ifdef ADD_SUB_EN
                        b_q      <= sub ? ~b : b;
                        carry    <= sub | cin;
`else
                        b_q      <= b;
                        carry    <= cin;
`endif
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*CHUNK +: CHUNK] <= s;
                    carry <= c;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(N - 1)) begin
                        cout      <= c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result held until taken; in_ready reopens on the next cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
// Subtract vectors run only when ADD_SUB_EN is defined.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, scramble inputs, wait (bounded) for out_valid, check result.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv, input logic [15:0] es,
                          input logic ec, input bit take);
        int cnt;
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~av; b = ~bv; cin = ~cv; sub = ~sv;
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 32'd4);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        if (take) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_ovdrop"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_irdy"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_ir", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Basic add, then asynchronous reset mid-cycle while result is held
        run_op("t2", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ov", {31'd0, out_valid}, 32'd0);
        chk("arst_sum", {16'd0, sum}, 32'd0);
        chk("arst_ir", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        tick();

        run_op("t3", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-pressure with a second request pending the whole time
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h1111; b = 16'h2222;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_ov", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_sum", {16'd0, sum}, 32'd0);
            chk("t4_hold_cout", {31'd0, cout}, 32'd1);
            chk("t4_hold_ir", {31'd0, in_ready}, 32'd0);
            chk("t4_hold_ov", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_hs_ov", {31'd0, out_valid}, 32'd0);
        chk("t4_hs_ir", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_acc2", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_ov2", {31'd0, out_valid}, 32'd1);
        chk("t4_sum2", {16'd0, sum}, 32'h3333);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset pulse during RUN at idx=2 discards the operation
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #2;
        chk("t5_ir", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                seen = seen | out_valid;
            end
            chk("t5_noov", {31'd0, seen}, 32'd0);
        end
        run_op("t5b", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);

`ifdef ADD_SUB_EN
        run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
        run_op("t6b", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1);
        run_op("t6c", 16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
